// File: rtl/dbus_core_port_pkg.sv
// Shared definitions for the per-core data-bus initiator: bus geometry, op codes,
// FSM encoding and the request-field bundle that is held on the bus.
package dbus_core_port_pkg;

    localparam int NCORES         = 4;
    localparam int DMEM_ADDRW_DEF = 14;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LW  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_LR  = 4'd8;
    localparam logic [3:0] OP_SC  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    typedef struct packed {
        logic        re;
        logic        we;
        logic        is_lr;
        logic        is_sc;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dbus_fields_t;

    // Undefined op codes are reported as errors so they never reach the bus.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LB, OP_LBU, OP_SB:       return 1'b0;
            OP_LH, OP_LHU, OP_SH:       return off[0];
            OP_LW, OP_SW, OP_LR, OP_SC: return off != 2'b00;
            default:                    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dbus_core_port_load_fmt.sv
// Turns the raw bus word into the value handed back to the core: lane select,
// sign/zero extension for loads, the SC status bit, zero for stores.
module dbus_load_fmt
    import dbus_core_port_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[{off, 3'b000} +: 8];
        half_sel = raw[{off[1], 4'b0000} +: 16];
        data     = '0;
        case (op)
            OP_LB:        data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:       data = {24'b0, byte_sel};
            OP_LH:        data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:       data = {16'b0, half_sel};
            OP_LW, OP_LR: data = raw;
            OP_SC:        data = {31'b0, raw[0]};
            default:      data = '0;
        endcase
    end

endmodule

// File: rtl/dbus_core_port.sv
// Per-core data-bus initiator: one load/store/LR/SC in flight, bus fields held
// across arbiter stalls, formatted response pulsed back to the memory stage.
module dbus_core_port
    import dbus_core_port_pkg::*;
#(
    parameter int DMEM_ADDRW = DMEM_ADDRW_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [3:0]            req_op_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  resp_valid_o,
    output logic [31:0]           resp_data_o,
    output logic                  resp_err_o,
    output logic                  dbus_re_o,
    output logic                  dbus_we_o,
    output logic [DMEM_ADDRW-1:0] dbus_addr_o,
    output logic [31:0]           dbus_wdata_o,
    output logic [3:0]            dbus_wstrb_o,
    output logic                  dbus_is_lr_o,
    output logic                  dbus_is_sc_o,
    input  logic [31:0]           dbus_rdata_i,
    input  logic                  dbus_stall_i
);

    state_e                state_q, state_d;
    logic [3:0]            op_q;
    logic [1:0]            off_q;
    dbus_fields_t          fld_q, fld_d;
    logic [DMEM_ADDRW-1:0] addr_q;
    logic                  resp_valid_q, resp_err_q;
    logic [31:0]           resp_data_q;
    logic [31:0]           fmt_data;
    logic                  bad_req;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^req_addr_i[31:DMEM_ADDRW+2];
    assign bad_req        = op_misaligned(req_op_i, req_addr_i[1:0]);

    always_comb begin
        fld_d = '0;
        case (req_op_i)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: fld_d.re = 1'b1;
            OP_LR: begin
                fld_d.re    = 1'b1;
                fld_d.is_lr = 1'b1;
            end
            OP_SB: begin
                fld_d.we    = 1'b1;
                fld_d.wstrb = 4'b0001 << req_addr_i[1:0];
                fld_d.wdata = {4{req_wdata_i[7:0]}};
            end
            OP_SH: begin
                fld_d.we    = 1'b1;
                fld_d.wstrb = 4'b0011 << req_addr_i[1:0];
                fld_d.wdata = {2{req_wdata_i[15:0]}};
            end
            OP_SW, OP_SC: begin
                fld_d.we    = 1'b1;
                fld_d.is_sc = (req_op_i == OP_SC);
                fld_d.wstrb = 4'b1111;
                fld_d.wdata = req_wdata_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid_i) state_d = bad_req ? ST_ERR : ST_ISSUE;
            ST_ISSUE: if (!dbus_stall_i) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Response regs default to zero every cycle so valid/err/data read as pulses;
    // an error response is raised while sitting in ERR, a normal one the cycle after RESP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            off_q        <= '0;
            fld_q        <= '0;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        op_q  <= req_op_i;
                        off_q <= req_addr_i[1:0];
                        if (bad_req) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            fld_q  <= fld_d;
                            addr_q <= req_addr_i[DMEM_ADDRW+1:2];
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!dbus_stall_i) begin
                        fld_q  <= '0;
                        addr_q <= '0;
                    end
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= fmt_data;
                end
                default: ;
            endcase
        end
    end

    dbus_load_fmt u_fmt (
        .op   (op_q),
        .off  (off_q),
        .raw  (dbus_rdata_i),
        .data (fmt_data)
    );

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_data_o  = resp_data_q;
    assign dbus_re_o    = fld_q.re;
    assign dbus_we_o    = fld_q.we;
    assign dbus_is_lr_o = fld_q.is_lr;
    assign dbus_is_sc_o = fld_q.is_sc;
    assign dbus_wstrb_o = fld_q.wstrb;
    assign dbus_wdata_o = fld_q.wdata;
    assign dbus_addr_o  = addr_q;

endmodule

// File: tb/tb_dbus_core_port.sv
// Scoreboard bench for dbus_core_port: stimulus pushes expected bus and response
// items from a byte-level memory model; bus and response monitors pop and compare.
`timescale 1ns/1ps
module tb_dbus_core_port;
    import dbus_core_port_pkg::*;

    localparam int AW = 10;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i, req_ready_o;
    logic [3:0]    req_op_i;
    logic [31:0]   req_addr_i, req_wdata_i;
    logic          resp_valid_o, resp_err_o;
    logic [31:0]   resp_data_o;
    logic          dbus_re_o, dbus_we_o, dbus_is_lr_o, dbus_is_sc_o;
    logic [AW-1:0] dbus_addr_o;
    logic [31:0]   dbus_wdata_o, dbus_rdata_i;
    logic [3:0]    dbus_wstrb_o;
    logic          dbus_stall_i;

    always #5 clk_i = ~clk_i;

    dbus_core_port #(.DMEM_ADDRW(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
        .dbus_re_o(dbus_re_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_wstrb_o(dbus_wstrb_o),
        .dbus_is_lr_o(dbus_is_lr_o), .dbus_is_sc_o(dbus_is_sc_o),
        .dbus_rdata_i(dbus_rdata_i), .dbus_stall_i(dbus_stall_i)
    );

    typedef struct {
        logic          re, we, lr, sc;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
        logic [31:0]   rdata;
        int            nstall;
    } bus_item_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } resp_item_t;

    bus_item_t   bus_q[$];
    resp_item_t  resp_q[$];
    logic [31:0] mem [int];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          gnt_cyc = -100;
    bit          chk_en = 1'b0;
    bit          abort = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [49:0] bus_all();
        return {dbus_re_o, dbus_we_o, dbus_is_lr_o, dbus_is_sc_o, dbus_addr_o, dbus_wdata_o, dbus_wstrb_o};
    endfunction

    // Bus side: acts as arbiter + memory, checks fields stay put while stalled.
    initial begin : bus_model
        bus_item_t   cur;
        bit          active = 1'b0;
        bit          post_gnt = 1'b0;
        bit          rd_next = 1'b0;
        int          stalls = 0;
        logic [31:0] rd_val = '0;
        dbus_stall_i = 1'b1;
        dbus_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            dbus_rdata_i = rd_next ? rd_val : $urandom;
            rd_next = 1'b0;
            if (!chk_en) begin
                active = 1'b0;
                post_gnt = 1'b0;
                dbus_stall_i = 1'b1;
                continue;
            end
            if (post_gnt) begin
                post_gnt = 1'b0;
                chk("bus_clear_after_grant", bus_all(), 0);
            end else if (!active && (dbus_re_o || dbus_we_o)) begin
                if (bus_q.size() == 0) chk("spurious_bus_access", 1, 0);
                else begin
                    cur = bus_q.pop_front();
                    active = 1'b1;
                    stalls = 0;
                end
            end
            if (active) begin
                chk("bus_ctl", {dbus_re_o, dbus_we_o, dbus_is_lr_o, dbus_is_sc_o},
                    {cur.re, cur.we, cur.lr, cur.sc});
                chk("bus_addr", dbus_addr_o, cur.addr);
                chk("bus_wstrb", dbus_wstrb_o, cur.wstrb);
                chk("bus_wdata", dbus_wdata_o, cur.wdata);
                if (stalls < cur.nstall) begin
                    stalls++;
                    dbus_stall_i = 1'b1;
                end else begin
                    dbus_stall_i = 1'b0;
                    active = 1'b0;
                    post_gnt = 1'b1;
                    rd_next = 1'b1;
                    rd_val = cur.rdata;
                    gnt_cyc = cyc;
                end
            end else begin
                dbus_stall_i = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : resp_monitor
        resp_item_t e;
        forever begin
            @(negedge clk_i);
            if (!chk_en) continue;
            if (resp_valid_o) begin
                if (resp_q.size() == 0) chk("spurious_resp", 1, 0);
                else begin
                    e = resp_q.pop_front();
                    chk("resp_data", resp_data_o, e.data);
                    chk("resp_err", resp_err_o, e.err);
                    chk("resp_cycle", cyc, e.err ? e.cyc : gnt_cyc + 2);
                end
            end else begin
                chk("resp_idle_zero", {resp_err_o, resp_data_o}, 0);
            end
        end
    end

    // Must be entered at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int nstall, input bit sc_fail);
        int          guard = 0;
        int          sz = 4;
        bit          ld = 1'b0, sgn = 1'b0;
        int          off, widx;
        logic [31:0] word, tmp;
        longint      v;
        resp_item_t  r;
        bus_item_t   b;
        while (!req_ready_o) begin
            req_valid_i = 1'($urandom_range(0, 1));
            req_op_i    = 4'($urandom_range(0, 15));
            req_addr_i  = $urandom;
            req_wdata_i = $urandom;
            @(negedge clk_i);
            if (++guard > 200) begin
                chk("ready_timeout", 0, 1);
                abort = 1'b1;
                return;
            end
        end
        case (op)
            OP_LB:        begin sz = 1; ld = 1; sgn = 1; end
            OP_LBU:       begin sz = 1; ld = 1; end
            OP_LH:        begin sz = 2; ld = 1; sgn = 1; end
            OP_LHU:       begin sz = 2; ld = 1; end
            OP_LW, OP_LR: begin sz = 4; ld = 1; end
            OP_SB:        sz = 1;
            OP_SH:        sz = 2;
            default:      sz = 4;
        endcase
        off  = int'(addr[1:0]);
        widx = int'(addr[AW+1:2]);
        word = mem.exists(widx) ? mem[widx] : 32'h0;
        r.err  = (off % sz) != 0;
        r.data = '0;
        r.cyc  = cyc + 1;
        if (!r.err) begin
            b.addr = addr[AW+1:2];
            b.re = ld;
            b.we = !ld;
            b.lr = (op == OP_LR);
            b.sc = (op == OP_SC);
            b.nstall = nstall;
            b.wstrb = '0;
            b.wdata = '0;
            b.rdata = $urandom;
            if (ld) begin
                b.rdata = word;
                v = (longint'(word) >> (8 * off)) & ((64'sd1 <<< (8 * sz)) - 1);
                if (sgn && ((v >> (8 * sz - 1)) & 1) != 0) v -= (64'sd1 <<< (8 * sz));
                r.data = v[31:0];
            end else begin
                b.wstrb = 4'(((1 << sz) - 1) << off);
                b.wdata = (sz == 1) ? {24'b0, wd[7:0]} * 32'h01010101 :
                          (sz == 2) ? {16'b0, wd[15:0]} * 32'h00010001 : wd;
                if (op == OP_SC) begin
                    tmp = $urandom;
                    b.rdata = {tmp[31:1], sc_fail};
                    r.data = {31'b0, sc_fail};
                end
                if (op != OP_SC || !sc_fail) begin
                    for (int k = 0; k < 4; k++)
                        if (b.wstrb[k]) word[8*k +: 8] = b.wdata[8*k +: 8];
                    mem[widx] = word;
                end
            end
            bus_q.push_back(b);
        end
        resp_q.push_back(r);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_addr_i  = addr;
        req_wdata_i = wd;
        @(negedge clk_i);
    endtask

    initial begin : stimulus
        logic [3:0]  op;
        logic [31:0] addr;
        req_valid_i = 1'b0;
        req_op_i    = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        repeat (3) @(negedge clk_i);
        chk("reset_ready", req_ready_o, 1);
        chk("reset_bus", bus_all(), 0);
        chk("reset_resp", {resp_valid_o, resp_err_o, resp_data_o}, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1 chk_en = 1'b1;
        @(negedge clk_i);

        mem[4] = 32'hDEADBEEF;
        issue(OP_LW, 32'h10, 32'h0, 0, 0);
        mem[4] = 32'h80FF0102;
        issue(OP_LB,  32'h13, 32'h0, 0, 0);
        issue(OP_LBU, 32'h13, 32'h0, 1, 0);
        issue(OP_LHU, 32'h12, 32'h0, 0, 0);
        issue(OP_SH,  32'h22, 32'h1234ABCD, 3, 0);
        issue(OP_SC,  32'h40, 32'hCAFEF00D, 0, 0);
        issue(OP_SC,  32'h40, 32'h0BADBEEF, 2, 1);
        issue(OP_LR,  32'h40, 32'h0, 1, 0);
        issue(OP_LW,  32'h06, 32'h0, 0, 0);
        issue(OP_SH,  32'h21, 32'h5555AAAA, 0, 0);
        issue(OP_LW,  32'hFFFF_F00C, 32'h0, 0, 0);

        for (int i = 0; i < 300 && !abort; i++) begin
            op   = 4'($urandom_range(0, 9));
            addr = $urandom & 32'hFFFF_F03F;
            issue(op, addr, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        req_valid_i = 1'b0;
        for (int g = 0; g < 200 && (resp_q.size() != 0 || bus_q.size() != 0 || !req_ready_o); g++)
            @(negedge clk_i);
        chk("drain_queues_empty", resp_q.size() + bus_q.size(), 0);

        @(posedge clk_i); #1 chk_en = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_op_i    = OP_LW;
        req_addr_i  = 32'h10;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("inflight_re", dbus_re_o, 1);
        chk("inflight_ready", req_ready_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("midreset_bus", bus_all(), 0);
        chk("midreset_ready", req_ready_o, 1);
        for (int i = 0; i < 4; i++) begin
            chk("midreset_no_resp", resp_valid_o, 0);
            @(negedge clk_i);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
